// File: rtl/vcpu_ctrl_pkg.sv
// Shared types and defaults for the vector CPU run controller.
// Optional single-step support is enabled by defining VCPU_STEP_EN.
package vcpu_ctrl_pkg;

   localparam int unsigned STATE_W = 3;

   localparam int unsigned DEF_CYC_W           = 32;
   localparam int unsigned DEF_CORE_RST_CYCLES = 4;
   localparam int unsigned DEF_DRAIN_CYCLES    = 3;
   localparam int unsigned DEF_TIMEOUT         = 100000;

   // Encoding is visible on state_o, keep it stable for debug tooling.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_CORE_RST = 3'd1,
      ST_RUN      = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_DONE     = 3'd4,
      ST_FAULT    = 3'd5
   } vcpu_run_state_e;

   // Width able to hold 0..max(a,b)-1 for the shared phase counter.
   function automatic int unsigned phase_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/vcpu_run_ctrl_if.sv
// Host/core control bundle around the run controller.
// Carries step_mode/step only when VCPU_STEP_EN is defined.
interface vcpu_run_ctrl_if
   import vcpu_ctrl_pkg::*;
#(
   parameter int unsigned CYC_W = DEF_CYC_W
) ();

   logic               start;
   logic               abort;
   logic               end_flag;
   logic               core_rst_n;
   logic               core_en;
   logic               busy;
   logic               done;
   logic               timeout;
   logic [CYC_W-1:0]   cycle_cnt;
   logic [STATE_W-1:0] state_o;
`ifdef VCPU_STEP_EN
   logic               step_mode;
   logic               step;

   modport master (
      output start, abort, end_flag, step_mode, step,
      input  core_rst_n, core_en, busy, done, timeout, cycle_cnt, state_o
   );

   modport slave (
      input  start, abort, end_flag, step_mode, step,
      output core_rst_n, core_en, busy, done, timeout, cycle_cnt, state_o
   );
`else
   modport master (
      output start, abort, end_flag,
      input  core_rst_n, core_en, busy, done, timeout, cycle_cnt, state_o
   );

   modport slave (
      input  start, abort, end_flag,
      output core_rst_n, core_en, busy, done, timeout, cycle_cnt, state_o
   );
`endif

endinterface

// File: rtl/vcpu_sat_counter.sv
// Up-counter with synchronous clear, enable and saturation at all-ones.
module vcpu_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/vcpu_run_ctrl.sv
// Sequences the vector core through reset, run, drain and completion with timeout.
// Define VCPU_STEP_EN to add single-step control of the core enable in RUN.
module vcpu_run_ctrl
   import vcpu_ctrl_pkg::*;
#(
   parameter int unsigned CYC_W           = DEF_CYC_W,
   parameter int unsigned CORE_RST_CYCLES = DEF_CORE_RST_CYCLES,
   parameter int unsigned DRAIN_CYCLES    = DEF_DRAIN_CYCLES,
   parameter int unsigned TIMEOUT         = DEF_TIMEOUT
) (
   input logic             clk,
   input logic             reset,
   vcpu_run_ctrl_if.slave  bus
);

   localparam int unsigned PH_W = phase_width(CORE_RST_CYCLES, DRAIN_CYCLES);
   localparam logic [PH_W-1:0] RST_LAST   = PH_W'(CORE_RST_CYCLES - 1);
   localparam logic [PH_W-1:0] DRAIN_LAST =
      PH_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
   localparam logic [CYC_W-1:0] TO_LAST   =
      CYC_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   vcpu_run_state_e  state_q, state_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             core_en_q, core_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;

   logic [CYC_W-1:0] cnt;
   logic [PH_W-1:0]  phase;
   logic             start_go;
   logic             to_hit;
   logic             run_en;
   logic             to_armed;
   logic             cnt_en;
   logic             ph_clr;

`ifdef VCPU_STEP_EN
   logic step_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_q <= 1'b0;
      end else begin
         step_q <= bus.step;
      end
   end

   // In step mode the core gets one enabled cycle per rising edge of step.
   assign run_en   = bus.step_mode ? (bus.step & ~step_q) : 1'b1;
   assign to_armed = ~bus.step_mode;
`else
   assign run_en   = 1'b1;
   assign to_armed = 1'b1;
`endif

   // cnt already holds this cycle's predecessor count; the edge that reaches
   // TIMEOUT is the one that also enters FAULT.
   assign to_hit = (TIMEOUT != 0) && to_armed && core_en_q && (cnt >= TO_LAST);

   always_comb begin
      state_d  = state_q;
      start_go = 1'b0;
      if (bus.abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
               if (bus.start) begin
                  state_d  = ST_CORE_RST;
                  start_go = 1'b1;
               end
            end
            ST_CORE_RST: begin
               if (phase == RST_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (bus.end_flag) begin
                  state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
               end else if (to_hit) begin
                  state_d = ST_FAULT;
               end
            end
            ST_DRAIN: begin
               if (phase == DRAIN_LAST) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      core_rst_n_d = state_d inside {ST_RUN, ST_DRAIN, ST_DONE, ST_FAULT};
      core_en_d    = ((state_d == ST_RUN) && run_en) || (state_d == ST_DRAIN);
      busy_d       = state_d inside {ST_CORE_RST, ST_RUN, ST_DRAIN};
      done_d       = (state_d == ST_DONE);
      timeout_d    = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         core_rst_n_q <= 1'b0;
         core_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         core_rst_n_q <= core_rst_n_d;
         core_en_q    <= core_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
      end
   end

   // Only cycles in which the core was actually enabled are counted.
   assign cnt_en = (state_q == ST_RUN) && core_en_q && !bus.abort;

   vcpu_sat_counter #(
      .W (CYC_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (start_go),
      .en    (cnt_en),
      .cnt   (cnt)
   );

   // CORE_RST and DRAIN never follow each other, so one phase counter serves both.
   assign ph_clr = !((state_q == ST_CORE_RST) || (state_q == ST_DRAIN));

   vcpu_sat_counter #(
      .W (PH_W)
   ) u_phase_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (ph_clr),
      .en    (!ph_clr),
      .cnt   (phase)
   );

   assign bus.core_rst_n = core_rst_n_q;
   assign bus.core_en    = core_en_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.cycle_cnt  = cnt;
   assign bus.state_o    = state_q;

endmodule

// File: doc/vcpu_run_ctrl.md
Name: vcpu_run_ctrl

Overview:
Run controller that sequences the vector CPU core through reset, execute, pipeline drain and completion.
- Turns a single `start` request into a controlled core reset and enable window.
- Watches the core's end flag, counts execution cycles, and enforces a timeout.
- Sits between the board/host control signals and the core's reset/enable inputs, wrapping the core inside the system top.

Parameters:
- CYC_W, 32, width of the cycle counter
- CORE_RST_CYCLES, 4, cycles `core_rst_n` is held low before each run (≥1)
- DRAIN_CYCLES, 3, cycles `core_en` stays high after `end_flag` so in-flight writebacks retire (≥0)
- TIMEOUT, 100000, RUN-cycle limit before fault; 0 disables the timeout

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  run request; level-sampled
- abort  in  1  forces return to IDLE
- end_flag  in  1  end-of-program flag from the core
- core_rst_n  out  1  active-low reset to the core
- core_en  out  1  core clock-enable / stall release
- busy  out  1  high in CORE_RST, RUN, DRAIN
- done  out  1  high in DONE
- timeout  out  1  high in FAULT
- cycle_cnt  out  CYC_W  RUN cycles of the current/last run
- state_o  out  3  encoded state, for debug

Behaviour:
- Reset (reset=0, async): state=IDLE, core_rst_n=0, core_en=0, busy=0, done=0, timeout=0, cycle_cnt=0. All outputs are registered.
- IDLE: core held in reset (core_rst_n=0, core_en=0). start=1 → CORE_RST on the next edge; cycle_cnt cleared to 0.
- CORE_RST:
  - core_rst_n=0, core_en=0 for exactly CORE_RST_CYCLES cycles, then → RUN.
  - core_rst_n rises on the same edge that enters RUN.
- RUN:
  - core_rst_n=1, core_en=1.
  - cycle_cnt increments every RUN cycle and saturates at all-ones.
  - end_flag=1 → DRAIN; cycle_cnt includes the cycle in which end_flag was seen.
- DRAIN:
  - core_en=1 for DRAIN_CYCLES cycles, then → DONE.
  - cycle_cnt frozen.
  - DRAIN_CYCLES=0 → RUN goes directly to DONE.
- DONE: core_rst_n=1 (core state and memories readable), core_en=0, done=1. Held until start.
- FAULT: entered from RUN when TIMEOUT≠0 and cycle_cnt reaches TIMEOUT with end_flag=0. core_rst_n=1, core_en=0, timeout=1. Held until start.
- start from DONE or FAULT → CORE_RST; done, timeout and cycle_cnt cleared on that edge.
- start while busy is ignored. start held high through DONE triggers an immediate rerun, by design.
- end_flag is ignored outside RUN (stale flags from a previous run have no effect).
- Priority when events coincide: reset > abort > end_flag > timeout.
- abort=1 in any state → IDLE next edge; core_rst_n=0, core_en=0 on that edge; done/timeout cleared; cycle_cnt retained.
- Reset asserted mid-run takes effect immediately and asynchronously; the next run requires a new start.

Optional Feature:
VCPU_STEP_EN
- Defined: adds inputs `step_mode` and `step`.
  - In RUN with step_mode=1, core_en is high for exactly one cycle per rising edge of `step`, otherwise low.
  - cycle_cnt counts only enabled cycles.
  - Timeout is suppressed while step_mode=1.
  - DRAIN ignores step_mode.
- Undefined: these ports do not exist; RUN enables the core every cycle.

Decomposition:
- Package vcpu_ctrl_pkg holds:
  - state enum vcpu_run_state_e (IDLE, CORE_RST, RUN, DRAIN, DONE, FAULT; 3-bit encoding exported on state_o)
  - STATE_W constant
  - default parameter constants
- Sub-module vcpu_sat_counter: parameterised up-counter with clear, enable and saturation. Used for cycle_cnt; a second instance serves as the shared CORE_RST/DRAIN phase counter.

Test Plan:
- Basic run (CORE_RST_CYCLES=4, DRAIN_CYCLES=3): start pulse; core raises end_flag on its 20th RUN cycle.
  → core_rst_n low for 4 cycles; done=1 exactly 3 cycles after end_flag; cycle_cnt=20; core_en=0 in DONE.
- Timeout (TIMEOUT=50, end_flag never asserted) → timeout=1 and state FAULT after RUN cycle 50; core_en=0; cycle_cnt=50.
- Coincident events:
  - end_flag and abort in the same cycle → IDLE, core_rst_n=0, done stays 0.
  - end_flag on the timeout cycle → DRAIN, timeout stays 0.
- Restart from DONE: start=1 → CORE_RST; done and cycle_cnt clear on the same edge. A stale end_flag=1 held during CORE_RST does not end the new run.
- Async reset mid-RUN (reset low for 3 ns between edges) → all outputs reach reset values immediately; no run until a new start.
- VCPU_STEP_EN, step_mode=1: 5 step pulses → exactly 5 single-cycle core_en pulses; cycle_cnt=5; no timeout with TIMEOUT=3.
